// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier: one add/subtract plus one arithmetic
// shift per clock, with the low product word and an overflow flag on completion.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW   = $clog2(WIDTH);
  localparam int NGRP = WIDTH / 4;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   start_accept, last_iter;

  logic [WIDTH:0]   acc_reg;
  logic [WIDTH-1:0] m_reg, q_reg;
  logic             q1_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] result_reg;
  logic             exc_reg;

  logic [WIDTH-1:0] add_a, add_b, add_g, add_p, add_c, add_sum;
  logic             add_cin, add_cout;
  logic [NGRP-1:0]  grp_g, grp_p;
  logic [NGRP:0]    grp_c;

  logic             sum_top;
  logic [WIDTH:0]   acc_shift;
  logic [WIDTH-1:0] q_shift;

  // Booth recoding of {Q[0], q_1}: subtract is ~M with carry-in
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case ({q_reg[0], q1_reg})
      2'b01: add_b = m_reg;
      2'b10: begin
        add_b   = ~m_reg;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_a = acc_reg[WIDTH-1:0];
  assign add_g = add_a & add_b;
  assign add_p = add_a ^ add_b;

  // Two-level carry lookahead: 4-bit groups, lookahead across group G/P
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    localparam int B = gi * 4;
    assign add_c[B]   = grp_c[gi];
    assign add_c[B+1] = add_g[B] | (add_p[B] & grp_c[gi]);
    assign add_c[B+2] = add_g[B+1] | (add_p[B+1] & add_g[B])
                      | (add_p[B+1] & add_p[B] & grp_c[gi]);
    assign add_c[B+3] = add_g[B+2] | (add_p[B+2] & add_g[B+1])
                      | (add_p[B+2] & add_p[B+1] & add_g[B])
                      | (add_p[B+2] & add_p[B+1] & add_p[B] & grp_c[gi]);
    assign grp_g[gi]  = add_g[B+3] | (add_p[B+3] & add_g[B+2])
                      | (add_p[B+3] & add_p[B+2] & add_g[B+1])
                      | (add_p[B+3] & add_p[B+2] & add_p[B+1] & add_g[B]);
    assign grp_p[gi]  = &add_p[B+3:B];
  end

  always_comb begin : lookahead
    logic carry;
    carry = add_cin;
    for (int k = 0; k < NGRP; k++) begin
      grp_c[k] = carry;
      carry    = grp_g[k] | (grp_p[k] & carry);
    end
    grp_c[NGRP] = carry;
  end

  assign add_sum  = add_p ^ add_c;
  assign add_cout = grp_c[NGRP];

  // Extra accumulator bit keeps -(-2^(WIDTH-1)) representable
  assign sum_top   = acc_reg[WIDTH] ^ add_b[WIDTH-1] ^ add_cout;
  assign acc_shift = {sum_top, sum_top, add_sum[WIDTH-1:1]};
  assign q_shift   = {add_sum[0], q_reg[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    start_accept   = 1'b0;
    last_iter      = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ctrl_MULT) begin
          start_accept = 1'b1;
          state_next   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count_reg == LAST_COUNT) begin
          last_iter  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        data_resultRDY = 1'b1;
        if (ctrl_MULT) begin
          start_accept = 1'b1;
          state_next   = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_reg    <= '0;
      m_reg      <= '0;
      q_reg      <= '0;
      q1_reg     <= 1'b0;
      count_reg  <= '0;
      result_reg <= '0;
      exc_reg    <= 1'b0;
    end else if (start_accept) begin
      acc_reg   <= '0;
      m_reg     <= data_operandA;
      q_reg     <= data_operandB;
      q1_reg    <= 1'b0;
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      acc_reg   <= acc_shift;
      q_reg     <= q_shift;
      q1_reg    <= q_reg[0];
      count_reg <= count_reg + 1'b1;
      if (last_iter) begin
        result_reg <= q_shift;
        exc_reg    <= (acc_shift[WIDTH-1:0] != {WIDTH{q_shift[WIDTH-1]}});
      end
    end
  end

  assign data_result    = result_reg;
  assign data_exception = exc_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: a cycle-level behavioural model built on
// plain signed multiplication, checked every cycle, plus directed literal cases.
module tb_booth_mult_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  booth_mult_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a multiply occupies 32 edges after its start edge, then the
  // product is visible with RDY for one cycle; starts are taken whenever not busy.
  bit          m_busy = 1'b0;
  bit          m_rdy = 1'b0;
  logic [31:0] m_result = '0;
  bit          m_exc = 1'b0;
  int          m_left = 0;
  logic [31:0] m_a = '0, m_b = '0;
  longint      m_prod;
  logic [63:0] m_prod_u;

  always @(posedge clock) begin
    if (reset) begin
      m_busy   = 1'b0;
      m_rdy    = 1'b0;
      m_result = '0;
      m_exc    = 1'b0;
      m_left   = 0;
    end else if (!m_busy && ctrl_MULT) begin
      m_a    = data_operandA;
      m_b    = data_operandB;
      m_busy = 1'b1;
      m_rdy  = 1'b0;
      m_left = 32;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_prod   = longint'($signed(m_a)) * longint'($signed(m_b));
        m_prod_u = m_prod;
        m_busy   = 1'b0;
        m_rdy    = 1'b1;
        m_result = m_prod_u[31:0];
        m_exc    = (m_prod_u[63:32] != {32{m_prod_u[31]}});
      end
    end else begin
      m_rdy = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("busy", busy, m_busy);
      check("rdy", data_resultRDY, m_rdy);
      check("result", data_result, m_result);
      check("exception", data_exception, m_exc);
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    #1;
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Returns at the negedge where RDY is seen; lat = edges after the start edge
  task automatic wait_rdy(output int lat);
    lat = 0;
    @(negedge clock);
    while (!data_resultRDY && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic exc);
    int lat;
    start_op(a, b);
    wait_rdy(lat);
    check({name, " latency"}, lat, 32);
    check({name, " result"}, data_result, res);
    check({name, " exception"}, data_exception, exc);
    check({name, " busy in rdy"}, busy, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h8000_0000;
      1: v = 32'h7FFF_FFFF;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h0000_0000;
      4: v = $urandom_range(0, 255) - 32'd128;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int lat;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clock);
    check("reset busy", busy, 1'b0);
    check("reset rdy", data_resultRDY, 1'b0);
    check("reset result", data_result, 32'h0);
    check("reset exception", data_exception, 1'b0);

    @(posedge clock);
    run_directed("3x4", 32'd3, 32'd4, 32'h0000_000C, 1'b0);
    @(posedge clock);
    run_directed("-7x6", -32'sd7, 32'd6, 32'hFFFF_FFD6, 1'b0);
    @(posedge clock);
    run_directed("-5x-5", -32'sd5, -32'sd5, 32'h0000_0019, 1'b0);
    // Back-to-back: next start lands in the RDY cycle
    run_directed("2^16x2^16", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_directed("maxpos x2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    @(posedge clock);
    run_directed("minneg x1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    @(posedge clock);
    run_directed("minneg x-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

    // Start request mid-run must be ignored
    @(posedge clock);
    start_op(32'h7FFF_FFFF, 32'd2);
    repeat (10) @(posedge clock);
    #1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
    wait_rdy(lat);
    check("restart latency", lat, 21);
    check("restart result", data_result, 32'hFFFF_FFFE);
    check("restart exception", data_exception, 1'b1);

    // Reset on iteration 10 abandons the run
    @(posedge clock);
    start_op(-32'sd7, 32'd6);
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midrun reset busy", busy, 1'b0);
    check("midrun reset rdy", data_resultRDY, 1'b0);
    check("midrun reset result", data_result, 32'h0);
    check("midrun reset exception", data_exception, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check("no rdy after reset", data_resultRDY, 1'b0);
    end

    // Randomized operands, random idle gaps or back-to-back starts
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = pick();
      b = pick();
      if ($urandom_range(0, 2) != 0) @(posedge clock);
      start_op(a, b);
      wait_rdy(lat);
      check("random latency", lat, 32);
    end

    @(posedge clock);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
